// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM between port 0 (CPU) and port 1 (loader/debug).
// Each access takes two cycles. In ARB the winner's request is latched, and
// in ISSUE it is driven to the RAM. A read returns rvalid/rdata one cycle
// after its ISSUE cycle, overlapping the next ARB.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   req/we/addr/wdata{0,1}           requests; held until the matching gnt
//   lock1                            port 1 keeps ownership while held with req1
//   gnt{0,1}, rvalid{0,1}            1-cycle grant / read-valid pulses
//   rdata                            shared read data, qualified by rvalidN
//   ram_w_en/ram_addr/ram_w_data     RAM drive; ram_r_data is the RAM read port
//   busy                             ISSUE cycle or read response outstanding
module mem_arbiter #(
  parameter int AW           = 8,
  parameter int DW           = 16,
  parameter bit CPU_PRIORITY = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  input  logic          lock1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          ram_w_en,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_w_data,
  input  logic [DW-1:0] ram_r_data,
  output logic          busy
);

  typedef enum logic {ARB = 1'b0, ISSUE = 1'b1} state_e;

  state_e        state_q, state_d;
  logic          lat_we_q, lat_we_d;
  logic [AW-1:0] lat_addr_q, lat_addr_d;
  logic [DW-1:0] lat_wdata_q, lat_wdata_d;
  logic          lat_id_q, lat_id_d;
  logic          last_q, last_d;      // port that won the previous access
  logic          owner_q, owner_d;    // port 1 holds the RAM under lock1
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_id_q    <= 1'b0;
      last_q      <= 1'b1;  // port 0 takes the first tie
      owner_q     <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      lat_we_q    <= lat_we_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      lat_id_q    <= lat_id_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata_q     <= rdata_d;
    end
  end

  // Winner selection, only meaningful when at least one port requests.
  always_comb begin
    win = 1'b0;
    if (owner_q && lock1 && req1) win = 1'b1;
    else if (req0 && !req1)       win = 1'b0;
    else if (req1 && !req0)       win = 1'b1;
    else if (CPU_PRIORITY)        win = 1'b0;
    else                          win = ~last_q;
  end

  always_comb begin
    state_d     = state_q;
    lat_we_d    = lat_we_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    lat_id_d    = lat_id_q;
    last_d      = last_q;
    owner_d     = owner_q;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    rdata_d     = rdata_q;
    case (state_q)
      ARB: begin
        // Ownership lapses as soon as port 1 stops holding lock1 with req1.
        if (!(lock1 && req1)) owner_d = 1'b0;
        if (req0 || req1) begin
          lat_id_d    = win;
          lat_we_d    = win ? we1    : we0;
          lat_addr_d  = win ? addr1  : addr0;
          lat_wdata_d = win ? wdata1 : wdata0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        state_d = ARB;
        last_d  = lat_id_q;
        owner_d = lat_id_q;
        // RAM read is combinational on ram_addr, so capture it here.
        if (!lat_we_q) begin
          rvalid0_d = ~lat_id_q;
          rvalid1_d = lat_id_q;
          rdata_d   = ram_r_data;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // Latched address/data only change on entry to ISSUE, so the RAM bus holds
  // its last value outside ISSUE without extra registers.
  assign ram_addr   = lat_addr_q;
  assign ram_w_data = lat_wdata_q;
  assign ram_w_en   = (state_q == ISSUE) && lat_we_q;
  assign gnt0       = (state_q == ISSUE) && !lat_id_q;
  assign gnt1       = (state_q == ISSUE) &&  lat_id_q;
  assign rvalid0    = rvalid0_q;
  assign rvalid1    = rvalid1_q;
  assign rdata      = rdata_q;
  assign busy       = (state_q == ISSUE) || rvalid0_q || rvalid1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, ram_w_en, busy;
  logic [DW-1:0] rdata, ram_w_data, ram_r_data;
  logic [AW-1:0] ram_addr;

  logic          p_req0 = 1'b0, p_req1 = 1'b0;
  logic          p_gnt0, p_gnt1, p_rv0, p_rv1, p_wen, p_busy;
  logic [DW-1:0] p_rdata, p_wd;
  logic [AW-1:0] p_addr;

  mem_arbiter #(.AW(AW), .DW(DW), .CPU_PRIORITY(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1), .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .ram_w_en(ram_w_en), .ram_addr(ram_addr), .ram_w_data(ram_w_data),
    .ram_r_data(ram_r_data), .busy(busy));

  mem_arbiter #(.AW(AW), .DW(DW), .CPU_PRIORITY(1'b1)) u_pri (
    .clk(clk), .rst_n(rst_n),
    .req0(p_req0), .we0(1'b0), .addr0(8'h01), .wdata0(16'h0000), .gnt0(p_gnt0), .rvalid0(p_rv0),
    .req1(p_req1), .we1(1'b0), .addr1(8'h02), .wdata1(16'h0000), .lock1(1'b0), .gnt1(p_gnt1), .rvalid1(p_rv1),
    .rdata(p_rdata), .ram_w_en(p_wen), .ram_addr(p_addr), .ram_w_data(p_wd),
    .ram_r_data(16'h0000), .busy(p_busy));

  // RAM behind the main instance: combinational read, written on the clock.
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == 8'h10) return 16'hBEEF;
    return {a, ~a} ^ 16'h3C5A;
  endfunction
  logic [DW-1:0] tb_ram [256];
  logic          tb_wr  [256];
  assign ram_r_data = (tb_wr[ram_addr] === 1'b1) ? tb_ram[ram_addr] : init_val(ram_addr);
  always @(posedge clk) if (ram_w_en) begin
    tb_ram[ram_addr] <= ram_w_data;
    tb_wr[ram_addr]  <= 1'b1;
  end

  // Reference model: per-port request queues, memory image, and a timeline of
  // expected events keyed by cycle number.
  typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic lock; } txn_t;
  txn_t          q0[$], q1[$];
  logic [DW-1:0] ref_mem [int];
  int            gnt_exp [int];
  logic [AW+DW-1:0] wr_exp [int];
  int            rv_port [int];
  logic [DW-1:0] rv_data [int];
  int cyc = 0, last_sched = 0, m_last = 1;
  bit m_owner = 1'b0;
  int errors = 0, checks = 0, wen_cnt = 0;
  int gseq[$];
  logic [DW-1:0] last_rd0 = '0;

  function automatic logic [DW-1:0] rd_ref(input logic [AW-1:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_val(a);
  endfunction

  function automatic txn_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic lk);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d; t.lock = lk;
    return t;
  endfunction

  task automatic model_clear();
    gnt_exp.delete(); wr_exp.delete(); rv_port.delete(); rv_data.delete();
    q0.delete(); q1.delete();
    m_last = 1; m_owner = 1'b0; last_sched = cyc;
  endtask

  // One clock of the main instance: compare, retire granted requests, present
  // queue heads, and decide the next access when the RAM is free.
  task automatic tick();
    int ge, w;
    txn_t t;
    @(negedge clk);
    cyc++;
    ge = gnt_exp.exists(cyc) ? gnt_exp[cyc] : -1;
    checks++; if (gnt0 !== (ge == 0)) begin errors++; $display("FAIL gnt0 cyc=%0d got=%b exp=%b", cyc, gnt0, ge == 0); end
    checks++; if (gnt1 !== (ge == 1)) begin errors++; $display("FAIL gnt1 cyc=%0d got=%b exp=%b", cyc, gnt1, ge == 1); end
    checks++; if (ram_w_en !== wr_exp.exists(cyc)) begin errors++; $display("FAIL ram_w_en cyc=%0d got=%b exp=%b", cyc, ram_w_en, wr_exp.exists(cyc)); end
    if (wr_exp.exists(cyc)) begin
      checks++; if ({ram_addr, ram_w_data} !== wr_exp[cyc]) begin errors++; $display("FAIL wr_bus cyc=%0d got=%h exp=%h", cyc, {ram_addr, ram_w_data}, wr_exp[cyc]); end
    end
    checks++; if (rvalid0 !== (rv_port.exists(cyc) && rv_port[cyc] == 0)) begin errors++; $display("FAIL rvalid0 cyc=%0d got=%b", cyc, rvalid0); end
    checks++; if (rvalid1 !== (rv_port.exists(cyc) && rv_port[cyc] == 1)) begin errors++; $display("FAIL rvalid1 cyc=%0d got=%b", cyc, rvalid1); end
    if (rv_port.exists(cyc)) begin
      checks++; if (rdata !== rv_data[cyc]) begin errors++; $display("FAIL rdata cyc=%0d got=%h exp=%h", cyc, rdata, rv_data[cyc]); end
    end
    if (ge >= 0) begin
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_issue cyc=%0d got=%b exp=1", cyc, busy); end
    end else if (!rv_port.exists(cyc)) begin
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_idle cyc=%0d got=%b exp=0", cyc, busy); end
    end
    if (gnt0) gseq.push_back(0);
    if (gnt1) gseq.push_back(1);
    if (rvalid0) last_rd0 = rdata;
    if (ram_w_en) wen_cnt++;
    if (ge == 0 && q0.size() > 0) void'(q0.pop_front());
    if (ge == 1 && q1.size() > 0) void'(q1.pop_front());
    if (ge >= 0) begin m_last = ge; m_owner = (ge == 1); end
    req0 = q0.size() > 0;
    if (req0) begin we0 = q0[0].we; addr0 = q0[0].addr; wdata0 = q0[0].wdata; end
    else begin we0 = 1'($urandom); addr0 = AW'($urandom); wdata0 = DW'($urandom); end
    req1 = q1.size() > 0;
    if (req1) begin we1 = q1[0].we; addr1 = q1[0].addr; wdata1 = q1[0].wdata; lock1 = q1[0].lock; end
    else begin we1 = 1'($urandom); addr1 = AW'($urandom); wdata1 = DW'($urandom); lock1 = 1'b0; end
    if (ge < 0) begin
      if (req0 || req1) begin
        if (m_owner && lock1 && req1) w = 1;
        else if (!req1)               w = 0;
        else if (!req0)               w = 1;
        else                          w = 1 - m_last;
        t = (w == 0) ? q0[0] : q1[0];
        gnt_exp[cyc+1] = w;
        if (t.we) begin
          wr_exp[cyc+1] = {t.addr, t.wdata};
          ref_mem[int'(t.addr)] = t.wdata;
          last_sched = cyc + 1;
        end else begin
          rv_port[cyc+2] = w;
          rv_data[cyc+2] = rd_ref(t.addr);
          last_sched = cyc + 2;
        end
      end
      if (!(lock1 && req1)) m_owner = 1'b0;
    end
  endtask

  task automatic run_idle(input int maxc);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || cyc < last_sched) && n < maxc) begin tick(); n++; end
    checks++;
    if (q0.size() > 0 || q1.size() > 0 || cyc < last_sched) begin
      errors++; $display("FAIL drain_timeout got=%0d/%0d pending exp=0", q0.size(), q1.size());
    end
    tick();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({gnt0, gnt1, rvalid0, rvalid1, ram_w_en, busy, rdata, ram_addr, ram_w_data} !== '0) begin
      errors++; $display("FAIL reset_outputs got=%h exp=0", {gnt0, gnt1, rvalid0, rvalid1, ram_w_en, busy, rdata, ram_addr, ram_w_data});
    end
    checks++;
    if ({p_gnt0, p_gnt1, p_rv0, p_rv1, p_wen, p_busy, p_rdata, p_addr, p_wd} !== '0) begin
      errors++; $display("FAIL reset_outputs_pri got=%h exp=0", {p_gnt0, p_gnt1, p_rv0, p_rv1, p_wen, p_busy, p_rdata, p_addr, p_wd});
    end
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_alternate();
    gseq.delete();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(1'b0, AW'(8'h30 + i), '0, 1'b0));
      q1.push_back(mk(1'b0, AW'(8'h50 + i), '0, 1'b0));
    end
    run_idle(100);
    checks++;
    if (gseq.size() != 8) begin errors++; $display("FAIL alt_count got=%0d exp=8", gseq.size()); end
    else for (int i = 0; i < 8; i++) begin
      checks++; if (gseq[i] != i % 2) begin errors++; $display("FAIL alt_order idx=%0d got=%0d exp=%0d", i, gseq[i], i % 2); end
    end
  endtask

  task automatic test_single_read();
    int w = wen_cnt;
    q0.push_back(mk(1'b0, 8'h10, '0, 1'b0));
    run_idle(20);
    checks++; if (last_rd0 !== 16'hBEEF) begin errors++; $display("FAIL single_read got=%h exp=beef", last_rd0); end
    checks++; if (wen_cnt != w) begin errors++; $display("FAIL single_read_wen got=%0d exp=0", wen_cnt - w); end
  endtask

  task automatic test_write_read();
    int w = wen_cnt;
    q1.push_back(mk(1'b1, 8'h20, 16'h1234, 1'b0));
    tick();
    q0.push_back(mk(1'b0, 8'h20, '0, 1'b0));
    run_idle(30);
    checks++; if (last_rd0 !== 16'h1234) begin errors++; $display("FAIL write_read got=%h exp=1234", last_rd0); end
    checks++; if (wen_cnt - w != 1) begin errors++; $display("FAIL write_read_wen got=%0d exp=1", wen_cnt - w); end
  endtask

  task automatic test_priority();
    int n0 = 0, n1 = 0, k = 0;
    int seq[$];
    @(negedge clk);
    p_req0 = 1'b1; p_req1 = 1'b1;
    while ((n0 < 4 || n1 < 4) && k < 60) begin
      @(negedge clk); k++;
      checks++; if ((p_gnt0 && p_gnt1) || (p_rv0 && p_rv1) || p_wen) begin errors++; $display("FAIL pri_excl got=%b%b%b%b%b exp=no overlap/no write", p_gnt0, p_gnt1, p_rv0, p_rv1, p_wen); end
      if (p_gnt0) begin n0++; seq.push_back(0); end
      if (p_gnt1) begin n1++; seq.push_back(1); end
      p_req0 = n0 < 4; p_req1 = n1 < 4;
    end
    p_req0 = 1'b0; p_req1 = 1'b0;
    checks++;
    if (seq.size() != 8) begin errors++; $display("FAIL pri_count got=%0d exp=8", seq.size()); end
    else for (int i = 0; i < 8; i++) begin
      checks++; if (seq[i] != (i >= 4 ? 1 : 0)) begin errors++; $display("FAIL pri_order idx=%0d got=%0d exp=%0d", i, seq[i], i >= 4); end
    end
  endtask

  task automatic test_lock();
    gseq.delete();
    for (int i = 0; i < 4; i++) q1.push_back(mk(1'b1, AW'(8'h40 + i), DW'(16'hA000 + i), 1'b1));
    tick(); tick();
    q0.push_back(mk(1'b0, 8'h41, '0, 1'b0));
    run_idle(60);
    checks++;
    if (gseq.size() != 5) begin errors++; $display("FAIL lock_count got=%0d exp=5", gseq.size()); end
    else for (int i = 0; i < 5; i++) begin
      checks++; if (gseq[i] != (i < 4 ? 1 : 0)) begin errors++; $display("FAIL lock_order idx=%0d got=%0d exp=%0d", i, gseq[i], i < 4); end
    end
    checks++; if (last_rd0 !== 16'hA001) begin errors++; $display("FAIL lock_read got=%h exp=a001", last_rd0); end
  endtask

  task automatic test_random();
    repeat (400) begin
      if (q0.size() < 2 && $urandom_range(0, 2) == 0)
        q0.push_back(mk(1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom), 1'b0));
      if (q1.size() < 2 && $urandom_range(0, 2) == 0)
        q1.push_back(mk(1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom), $urandom_range(0, 3) == 0));
      tick();
    end
    run_idle(200);
  endtask

  task automatic test_reset_in_issue();
    q0.push_back(mk(1'b0, 8'h05, '0, 1'b0));
    tick(); tick();  // second tick is the ISSUE cycle and checks gnt0
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt0, gnt1, rvalid0, rvalid1, ram_w_en, busy, rdata, ram_addr, ram_w_data} !== '0) begin
      errors++; $display("FAIL rst_issue_outputs got=%h exp=0", {gnt0, gnt1, rvalid0, rvalid1, ram_w_en, busy, rdata, ram_addr, ram_w_data});
    end
    repeat (2) begin
      @(negedge clk);
      checks++; if ({gnt0, gnt1, rvalid0, rvalid1, ram_w_en} !== '0) begin errors++; $display("FAIL rst_hold got=%b exp=0", {gnt0, gnt1, rvalid0, rvalid1, ram_w_en}); end
    end
    rst_n = 1'b1;
    model_clear();
    gseq.delete();
    q0.push_back(mk(1'b0, 8'h06, '0, 1'b0));
    q1.push_back(mk(1'b0, 8'h07, '0, 1'b0));
    run_idle(30);
    checks++;
    if (gseq.size() != 2 || gseq[0] != 0) begin errors++; $display("FAIL rst_first_tie got=%0d exp=0", gseq.size() > 0 ? gseq[0] : -1); end
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_single_read();
    test_write_read();
    test_priority();
    test_lock();
    test_random();
    test_reset_in_issue();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
